// File: rtl/rgmii_rx_nibble_align_if.sv
`default_nettype none
// ============================================================================
// Module  : rgmii_rx_nibble_align_if
// Brief   : GMII-side receive inputs plus aligned byte / in-band status outputs
// Revision: 1.0
// ============================================================================
interface rgmii_rx_nibble_align_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [1:0] speed;
  logic [7:0] out_rxd;
  logic       out_rx_dv;
  logic       out_rx_er;
  logic       out_rx_clk_en;
  logic       ibs_link;
  logic [1:0] ibs_speed;
  logic       ibs_duplex;
  logic       ibs_valid;

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, speed,
    output out_rxd, out_rx_dv, out_rx_er, out_rx_clk_en,
    output ibs_link, ibs_speed, ibs_duplex, ibs_valid
  );

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, speed,
    input  out_rxd, out_rx_dv, out_rx_er, out_rx_clk_en,
    input  ibs_link, ibs_speed, ibs_duplex, ibs_valid
  );
endinterface
`default_nettype wire

// File: rtl/rgmii_rx_nibble_align.sv
`default_nettype none
// ============================================================================
// Module  : rgmii_rx_nibble_align
// Brief   : RGMII receive nibble-to-byte aligner with in-band status decode
// Revision: 1.0
// ============================================================================
module rgmii_rx_nibble_align #(
  parameter int IBS_FILTER = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  rgmii_rx_nibble_align_if.slave bus
);

  localparam logic [3:0] c_filt = 4'(IBS_FILTER);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DATA_LO  = 3'd2,
    S_DATA_HI  = 3'd3,
    S_DROP     = 3'd4,
    S_TERM     = 3'd5
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_toggle, w_toggle_nxt;
  logic [3:0] r_lo, w_lo_nxt;
  logic       r_lo_er, w_lo_er_nxt;
  logic [1:0] r_speed;

  logic       w_emit;
  logic [7:0] w_emit_rxd;
  logic       w_emit_dv;
  logic       w_emit_er;

  logic [7:0] r_out_rxd;
  logic       r_out_dv;
  logic       r_out_er;
  logic       r_out_clk_en;

  logic [3:0] r_ibs_cnt;
  logic [3:0] r_ibs_prev;
  logic       r_ibs_link;
  logic [1:0] r_ibs_speed;
  logic       r_ibs_duplex;
  logic       r_ibs_valid;

  logic       w_gig;
  logic [3:0] w_nib;
  logic       w_dv;
  logic       w_er;
  logic       w_sample;

  assign w_gig    = r_speed[1];
  assign w_nib    = bus.gmii_rxd[3:0];
  assign w_dv     = bus.gmii_rx_dv;
  assign w_er     = bus.gmii_rx_er;
  assign w_sample = !w_dv && !w_er;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_toggle <= 1'b0;
      r_lo     <= 4'h0;
      r_lo_er  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_toggle <= w_toggle_nxt;
      r_lo     <= w_lo_nxt;
      r_lo_er  <= w_lo_er_nxt;
    end
  end

  // A plain emit with all fields zero is the end-of-frame terminator.
  always_comb begin
    w_state_nxt  = r_state;
    w_toggle_nxt = r_toggle;
    w_lo_nxt     = r_lo;
    w_lo_er_nxt  = r_lo_er;
    w_emit       = 1'b0;
    w_emit_rxd   = 8'h00;
    w_emit_dv    = 1'b0;
    w_emit_er    = 1'b0;
    if (w_gig) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dv) begin
            if (w_nib == 4'h5) begin
              w_state_nxt  = S_PREAMBLE;
              w_toggle_nxt = 1'b0;
            end else if (w_nib == 4'hD) begin
              w_emit      = 1'b1;
              w_emit_rxd  = 8'hD5;
              w_emit_dv   = 1'b1;
              w_emit_er   = w_er;
              w_state_nxt = S_DATA_LO;
            end else begin
              w_state_nxt  = S_DROP;
              w_toggle_nxt = 1'b0;
            end
          end
        end
        S_PREAMBLE: begin
          if (!w_dv) begin
            w_emit      = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_nib == 4'h5) begin
            w_toggle_nxt = ~r_toggle;
            if (!r_toggle) begin
              w_emit     = 1'b1;
              w_emit_rxd = 8'h55;
              w_emit_dv  = 1'b1;
            end
          end else if (w_nib == 4'hD) begin
            w_emit      = 1'b1;
            w_emit_rxd  = 8'hD5;
            w_emit_dv   = 1'b1;
            w_emit_er   = w_er;
            w_state_nxt = S_DATA_LO;
          end else begin
            w_state_nxt  = S_DROP;
            w_toggle_nxt = 1'b0;
          end
        end
        S_DATA_LO: begin
          if (w_dv) begin
            w_lo_nxt    = w_nib;
            w_lo_er_nxt = w_er;
            w_state_nxt = S_DATA_HI;
          end else begin
            w_emit      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_DATA_HI: begin
          w_emit     = 1'b1;
          w_emit_dv  = 1'b1;
          if (w_dv) begin
            w_emit_rxd  = {w_nib, r_lo};
            w_emit_er   = r_lo_er | w_er;
            w_state_nxt = S_DATA_LO;
          end else begin
            w_emit_rxd  = {4'h0, r_lo};
            w_emit_er   = 1'b1;
            w_state_nxt = S_TERM;
          end
        end
        S_DROP: begin
          if (w_dv) begin
            w_toggle_nxt = ~r_toggle;
            if (!r_toggle) begin
              w_emit    = 1'b1;
              w_emit_dv = 1'b1;
              w_emit_er = 1'b1;
            end
          end else begin
            w_emit      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_TERM: begin
          w_emit      = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Speed only follows the input between frames so a frame never changes mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed <= 2'b10;
    end else if (r_state == S_IDLE && !w_dv) begin
      r_speed <= bus.speed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_rxd    <= 8'h00;
      r_out_dv     <= 1'b0;
      r_out_er     <= 1'b0;
      r_out_clk_en <= 1'b0;
    end else if (w_gig) begin
      r_out_rxd    <= bus.gmii_rxd;
      r_out_dv     <= w_dv;
      r_out_er     <= w_er;
      r_out_clk_en <= 1'b1;
    end else begin
      r_out_clk_en <= w_emit;
      if (w_emit) begin
        r_out_rxd <= w_emit_rxd;
        r_out_dv  <= w_emit_dv;
        r_out_er  <= w_emit_er;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ibs_cnt  <= 4'h0;
      r_ibs_prev <= 4'h0;
    end else if (w_sample) begin
      r_ibs_prev <= w_nib;
      if (r_ibs_cnt != 4'h0 && w_nib == r_ibs_prev) begin
        r_ibs_cnt <= (r_ibs_cnt >= c_filt) ? c_filt : r_ibs_cnt + 4'h1;
      end else begin
        r_ibs_cnt <= 4'h1;
      end
    end else begin
      r_ibs_cnt <= 4'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ibs_link   <= 1'b0;
      r_ibs_speed  <= 2'b00;
      r_ibs_duplex <= 1'b0;
      r_ibs_valid  <= 1'b0;
    end else if (r_ibs_cnt == c_filt) begin
      r_ibs_link   <= r_ibs_prev[0];
      r_ibs_speed  <= r_ibs_prev[2:1];
      r_ibs_duplex <= r_ibs_prev[3];
      r_ibs_valid  <= 1'b1;
    end
  end

  assign bus.out_rxd       = r_out_rxd;
  assign bus.out_rx_dv     = r_out_dv;
  assign bus.out_rx_er     = r_out_er;
  assign bus.out_rx_clk_en = r_out_clk_en;
  assign bus.ibs_link      = r_ibs_link;
  assign bus.ibs_speed     = r_ibs_speed;
  assign bus.ibs_duplex    = r_ibs_duplex;
  assign bus.ibs_valid     = r_ibs_valid;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_rx_nibble_align.sv
`default_nettype none
// ============================================================================
// Module  : tb_rgmii_rx_nibble_align
// Brief   : Directed self-checking bench for rgmii_rx_nibble_align
// Revision: 1.0
// ============================================================================
module tb_rgmii_rx_nibble_align;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [9:0] cap[$];
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  rgmii_rx_nibble_align_if bus ();

  rgmii_rx_nibble_align #(.IBS_FILTER(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each step drives one input cycle; on return the outputs reflect that cycle.
  task automatic step(input logic [7:0] d, input logic dv, input logic er);
    @(negedge clk);
    bus.gmii_rxd   = d;
    bus.gmii_rx_dv = dv;
    bus.gmii_rx_er = er;
    @(posedge clk);
    #1;
    if (bus.out_rx_clk_en === 1'b1)
      cap.push_back({bus.out_rx_er, bus.out_rx_dv, bus.out_rxd});
  endtask

  task automatic nib(input logic [3:0] n, input int count);
    for (int k = 0; k < count; k++) step({4'h0, n}, 1'b1, 1'b0);
  endtask

  task automatic check_frame(input string tag);
    chk($sformatf("%s_len", tag), cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk($sformatf("%s_%0d", tag, i), {22'h0, cap[i]}, {22'h0, exp_q[i]});
    cap.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] gig_bytes [8];
    gig_bytes = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hAA};

    bus.speed      = 2'b10;
    bus.gmii_rxd   = 8'h0D;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rxd",    bus.out_rxd, 0);
    chk("rst_dv",     bus.out_rx_dv, 0);
    chk("rst_er",     bus.out_rx_er, 0);
    chk("rst_clk_en", bus.out_rx_clk_en, 0);
    chk("rst_valid",  bus.ibs_valid, 0);
    chk("rst_link",   bus.ibs_link, 0);
    rst = 1'b0;

    // In-band status filter: 0xD once, then 0x5 three times.
    step(8'h0D, 1'b0, 1'b0);
    chk("gig_clk_en_idle", bus.out_rx_clk_en, 1);
    step(8'h05, 1'b0, 1'b0);
    chk("ibs_hold_valid", bus.ibs_valid, 0);
    chk("ibs_hold_link",  bus.ibs_link, 0);
    step(8'h05, 1'b0, 1'b0);
    step(8'h05, 1'b0, 1'b0);
    chk("ibs_link",   bus.ibs_link, 1);
    chk("ibs_speed",  bus.ibs_speed, 2'b10);
    chk("ibs_duplex", bus.ibs_duplex, 0);
    chk("ibs_valid",  bus.ibs_valid, 1);

    // 1G passthrough.
    for (int i = 0; i < 8; i++) begin
      step(gig_bytes[i], 1'b1, 1'b0);
      chk($sformatf("gig_rxd_%0d", i), bus.out_rxd, gig_bytes[i]);
      chk($sformatf("gig_dv_%0d", i), bus.out_rx_dv, 1);
      chk($sformatf("gig_en_%0d", i), bus.out_rx_clk_en, 1);
    end
    step(8'h00, 1'b0, 1'b0);
    chk("gig_end_dv", bus.out_rx_dv, 0);
    chk("gig_end_en", bus.out_rx_clk_en, 1);

    // Switch to 100M between frames.
    bus.speed = 2'b01;
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("mode_100m_en", bus.out_rx_clk_en, 0);
    cap.delete();

    // 100M: 15x5, D, 1,2,3,4.
    nib(4'h5, 15); nib(4'hD, 1);
    nib(4'h1, 1); nib(4'h2, 1); nib(4'h3, 1); nib(4'h4, 1);
    step(8'h00, 1'b0, 1'b0);
    repeat (7) exp_q.push_back(10'h155);
    exp_q.push_back(10'h1D5); exp_q.push_back(10'h121);
    exp_q.push_back(10'h143); exp_q.push_back(10'h000);
    check_frame("f100");

    // 10M: 14x5, D, A,B,C (odd nibble count).
    bus.speed = 2'b00;
    step(8'h00, 1'b0, 1'b0);
    cap.delete();
    nib(4'h5, 14); nib(4'hD, 1);
    nib(4'hA, 1); nib(4'hB, 1); nib(4'hC, 1);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    repeat (7) exp_q.push_back(10'h155);
    exp_q.push_back(10'h1D5); exp_q.push_back(10'h1BA);
    exp_q.push_back(10'h30C); exp_q.push_back(10'h000);
    check_frame("f10odd");

    // 100M: rx_er on the high nibble of the second data byte.
    bus.speed = 2'b01;
    step(8'h00, 1'b0, 1'b0);
    cap.delete();
    nib(4'h5, 2); nib(4'hD, 1);
    nib(4'h1, 1); nib(4'h2, 1); nib(4'h3, 1);
    step(8'h04, 1'b1, 1'b1);
    nib(4'h5, 1); nib(4'h6, 1);
    step(8'h00, 1'b0, 1'b0);
    exp_q.push_back(10'h155); exp_q.push_back(10'h1D5);
    exp_q.push_back(10'h121); exp_q.push_back(10'h343);
    exp_q.push_back(10'h165); exp_q.push_back(10'h000);
    check_frame("f100er");

    // Speed changed to 1G mid-frame: frame finishes in nibble mode.
    nib(4'h5, 2); nib(4'hD, 1); nib(4'h1, 1); nib(4'h2, 1);
    bus.speed = 2'b10;
    nib(4'h3, 1); nib(4'h4, 1);
    step(8'h00, 1'b0, 1'b0);
    exp_q.push_back(10'h155); exp_q.push_back(10'h1D5);
    exp_q.push_back(10'h121); exp_q.push_back(10'h143);
    exp_q.push_back(10'h000);
    check_frame("fswitch");
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("switch_gig_en", bus.out_rx_clk_en, 1);
    step(8'h5A, 1'b1, 1'b0);
    chk("switch_gig_rxd", bus.out_rxd, 8'h5A);
    chk("switch_gig_dv",  bus.out_rx_dv, 1);
    step(8'h00, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a 100M frame.
    bus.speed = 2'b01;
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    nib(4'h5, 2); nib(4'hD, 1); nib(4'h1, 1);
    chk("pre_rst_rxd",   bus.out_rxd, 8'hD5);
    chk("pre_rst_valid", bus.ibs_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rxd",    bus.out_rxd, 0);
    chk("arst_dv",     bus.out_rx_dv, 0);
    chk("arst_er",     bus.out_rx_er, 0);
    chk("arst_clk_en", bus.out_rx_clk_en, 0);
    chk("arst_valid",  bus.ibs_valid, 0);
    chk("arst_speed",  bus.ibs_speed, 0);
    rst = 1'b0;
    step(8'h00, 1'b0, 1'b0);
    chk("post_rst_gig_en", bus.out_rx_clk_en, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgmii_rx_nibble_align.md
Name: rgmii_rx_nibble_align

Overview:
- Sits directly downstream of the RGMII PHY interface receive path, in the `mac_gmii_rx_clk` domain, feeding the MAC receive logic.
- At 1G, passes GMII bytes through with one cycle of latency.
- At 10/100, each `rx_clk` cycle carries one nibble on `rxd[3:0]`. The block detects the SFD, aligns nibble pairs into bytes and outputs bytes qualified by a clock-enable strobe.
- Also decodes RGMII in-band status (link/speed/duplex) sent by the PHY during the inter-frame gap.

Parameters:
- IBS_FILTER, 2, number of consecutive identical inter-frame status samples required before the in-band status outputs update (1..15).

Ports:
- clk  input  1  receive clock (`mac_gmii_rx_clk`)
- rst  input  1  reset, asynchronous, active-high
- gmii_rxd  input  8  receive data from the PHY interface
- gmii_rx_dv  input  1  receive data valid
- gmii_rx_er  input  1  receive error (`ctl1^ctl2`)
- speed  input  2  link speed: 2'b10 = 1G, 2'b01 = 100M, 2'b00 = 10M; 2'b11 is treated as 1G
- out_rxd  output  8  aligned receive byte
- out_rx_dv  output  1  aligned data valid
- out_rx_er  output  1  aligned error
- out_rx_clk_en  output  1  byte strobe; consumer samples the out_* signals only when high
- ibs_link  output  1  in-band link up
- ibs_speed  output  2  in-band speed, same encoding as `speed`
- ibs_duplex  output  1  in-band duplex (1 = full)
- ibs_valid  output  1  high once any in-band status has been accepted

Behaviour:
- Reset (async, active-high): all outputs 0; FSM to IDLE; filter counter 0; `speed_reg` = 2'b10.
- speed_reg:
  - `speed` is sampled into `speed_reg` only while the FSM is IDLE and `gmii_rx_dv`=0.
  - A change of `speed` mid-frame takes effect after the frame ends.
- 1G mode (`speed_reg`=2'b10/11):
  - `out_rxd`/`out_rx_dv`/`out_rx_er` are the inputs registered once (latency 1).
  - `out_rx_clk_en`=1 every cycle.
  - FSM stays in IDLE.
- 10/100 mode: FSM states IDLE, PREAMBLE, DATA_LO, DATA_HI, DROP. Only `gmii_rxd[3:0]` is used. `out_rx_clk_en` defaults to 0 and pulses for exactly one cycle per emitted item. Emissions are registered, one cycle after the triggering input cycle.
  - IDLE:
    - `dv`=1 with nibble 0x5 -> PREAMBLE, pair toggle cleared.
    - `dv`=1 with nibble 0xD -> emit 0xD5 (dv=1, er=`rx_er`) -> DATA_LO.
    - `dv`=1 with any other nibble -> DROP.
  - PREAMBLE:
    - nibble 0x5: toggle flips; on every second 0x5, emit 0x55 with dv=1.
    - nibble 0xD: emit 0xD5 regardless of toggle (self-aligning on SFD) -> DATA_LO.
    - any other nibble -> DROP.
    - `dv`=0 -> emit terminator, then IDLE.
  - DATA_LO:
    - `dv`=1: latch low nibble and `er` -> DATA_HI.
    - `dv`=0: emit terminator (dv=0, er=0, rxd=0), then IDLE.
  - DATA_HI:
    - `dv`=1: emit {`rxd[3:0]`, latched lo}, er = latched er | `rx_er` -> DATA_LO.
    - `dv`=0 (odd nibble count): emit {4'h0, lo} with dv=1, er=1. Next cycle emit terminator, then IDLE.
  - DROP:
    - each even-indexed nibble emits rxd=0, dv=1, er=1.
    - `dv`=0 -> emit terminator, then IDLE.
  - Terminator: a single strobe with dv=0, er=0, rxd=0. It closes every frame in 10/100 mode.
- In-band status (all speeds):
  - A sample is a cycle with `gmii_rx_dv`=0 and `gmii_rx_er`=0.
  - Field decode: `rxd[0]`=link, `rxd[2:1]`=speed, `rxd[3]`=duplex.
  - A 4-bit counter counts consecutive samples equal to the previous sample. It resets to 1 on mismatch and saturates at IBS_FILTER.
  - When the count reaches IBS_FILTER, outputs update on the next cycle and `ibs_valid` is set.
  - Cycles with `dv`=1, or with `er`=1 while `dv`=0 (carrier extension / false carrier), clear the counter but leave the outputs unchanged.
- Reset asserted mid-frame: immediate return to reset values; no terminator is emitted.

Test Plan:
- 100M, speed=01: 15×0x5, 0xD, then nibbles 1,2,3,4, `dv` falls -> seven strobes 0x55, then 0xD5, 0x21, 0x43; then terminator dv=0; no er.
- 10M, 14×0x5 then 0xD, 0xA,0xB,0xC (odd) -> 0x55×7, 0xD5, 0xBA, then {0,C} with dv=1 er=1, then terminator.
- 100M, `rx_er` pulsed on the high nibble of the 2nd data byte -> that byte has er=1; other bytes er=0.
- 1G, 8-byte frame 55..D5,AA -> identical bytes delayed 1 cycle, `out_rx_clk_en` constantly 1.
- IFG with `rxd`=0xD for 1 cycle, then 0x5 for 3 cycles (IBS_FILTER=2) -> outputs stay 0 until after the 2nd 0x5 sample; then link=1, speed=10, duplex=0, valid=1.
- `speed` changed 01->10 mid-frame -> frame completes in nibble mode with a terminator; passthrough starts at the next idle cycle. Async `rst` mid-frame -> all outputs 0 immediately.
